// File: rtl/bcd_pkg.sv
// Shared types and elaboration helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FIN
  } state_t;

  // Number of decimal digits needed to hold 2**bin_w - 1.
  function automatic int min_digits(input int bin_w);
    longint unsigned max_val;
    int              d;
    max_val = (64'd1 << bin_w) - 64'd1;
    d = 1;
    while (max_val >= 64'd10) begin
      d++;
      max_val = max_val / 64'd10;
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_seq_add3.sv
// Double-dabble correction cell: adds 3 to a BCD digit that is 5 or more.
module add3
  import bcd_pkg::*;
(
  input  bcd_digit_t a,
  output bcd_digit_t y
);

  assign y = (a >= 4'd5) ? a + 4'd3 : a;

endmodule

// File: rtl/bcd_seq.sv
// Multi-cycle binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Optional BCD_BLANK_EN adds a registered leading-zero blanking output.
module bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
`ifdef BCD_BLANK_EN
  output logic [DIGITS-1:0]     blank,
`endif
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int SCR_W  = 4 * DIGITS;
  localparam int WORK_W = SCR_W + BIN_W;
  localparam int CNT_W  = $clog2(BIN_W + 1);

  generate
    if (BIN_W < 4 || BIN_W > 32) begin : g_bad_width
      $fatal(1, "bcd_seq: BIN_W=%0d outside 4..32", BIN_W);
    end
    if (DIGITS < min_digits(BIN_W)) begin : g_bad_digits
      $fatal(1, "bcd_seq: DIGITS=%0d too small for BIN_W=%0d", DIGITS, BIN_W);
    end
  endgenerate

  state_t             state_reg, state_next;
  logic [WORK_W-1:0]  work_reg;      // {scratch digits, remaining binary bits}
  logic [WORK_W-1:0]  work_fix;
  logic [WORK_W-1:0]  work_next;
  logic [SCR_W-1:0]   scratch_fix;
  logic [CNT_W-1:0]   count_reg;
  logic               accept;
  logic               last;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_add3
      add3 u_add3 (
        .a (work_reg[BIN_W + 4*gi +: 4]),
        .y (scratch_fix[4*gi +: 4])
      );
    end
  endgenerate

  // Correction first, then one left shift of the whole work vector.
  assign work_fix  = {scratch_fix, work_reg[BIN_W-1:0]};
  assign work_next = work_fix << 1;
  assign last      = (count_reg == CNT_W'(1));

`ifdef BCD_BLANK_EN
  logic [DIGITS-1:0] blank_next;
  assign blank_next[0] = 1'b0;
  generate
    for (gi = 1; gi < DIGITS; gi++) begin : g_blank
      assign blank_next[gi] = ~|work_next[WORK_W-1 : BIN_W + 4*gi];
    end
  endgenerate
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (last) begin
          state_next = FIN;
        end
      end
      FIN: begin
        done = 1'b1;
        if (start) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // bcd is loaded on the final shift edge so it is valid throughout the FIN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_reg  <= '0;
      count_reg <= '0;
      bcd       <= '0;
`ifdef BCD_BLANK_EN
      blank     <= {{(DIGITS-1){1'b1}}, 1'b0};
`endif
    end else if (accept) begin
      work_reg  <= {{SCR_W{1'b0}}, bin};
      count_reg <= CNT_W'(BIN_W);
    end else if (state_reg == SHIFT) begin
      work_reg  <= work_next;
      count_reg <= count_reg - CNT_W'(1);
      if (last) begin
        bcd   <= work_next[WORK_W-1:BIN_W];
`ifdef BCD_BLANK_EN
        blank <= blank_next;
`endif
      end
    end
  end

endmodule

// File: tb/tb_bcd_seq.sv
// Randomised scoreboard bench for bcd_seq (BIN_W=16, DIGITS=5), decimal reference model.
module tb_bcd_seq;

  localparam int BIN_W  = 16;
  localparam int DIGITS = 5;

  logic                 clk   = 1'b0;
  logic                 rst_n = 1'b1;
  logic                 start = 1'b0;
  logic [BIN_W-1:0]     bin   = '0;
  logic                 busy;
  logic                 done;
  logic [4*DIGITS-1:0]  bcd;
`ifdef BCD_BLANK_EN
  logic [DIGITS-1:0]    blank;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int val;
    int stamp;
  } exp_t;
  exp_t exp_q[$];

  logic [4*DIGITS-1:0] last_bcd = '0;
  logic                done_prev = 1'b0;

  bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
`ifdef BCD_BLANK_EN
    .blank (blank),
`endif
    .bcd   (bcd)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Decimal digits of v by repeated division.
  function automatic logic [4*DIGITS-1:0] ref_bcd(input int v);
    logic [4*DIGITS-1:0] r;
    int rem;
    r   = '0;
    rem = v;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(rem % 10);
      rem = rem / 10;
    end
    return r;
  endfunction

  // Digit k is blank when the value has no more than k significant digits.
  function automatic logic [DIGITS-1:0] ref_blank(input int v);
    logic [DIGITS-1:0] b;
    int p;
    b = '0;
    p = 1;
    for (int k = 1; k < DIGITS; k++) begin
      p = p * 10;
      b[k] = (v < p);
    end
    return b;
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pop expected result on every done pulse, otherwise bcd must hold.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (done) begin
        check("done_width", longint'(done_prev), 0);
        if (exp_q.size() == 0) begin
          check("spurious_done", longint'(done), 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("bcd", longint'(bcd), longint'(ref_bcd(e.val)));
          check("latency", longint'(cyc - e.stamp), BIN_W);
`ifdef BCD_BLANK_EN
          check("blank", longint'(blank), longint'(ref_blank(e.val)));
`endif
          $display("result bin=%0d bcd=%0h", e.val, bcd);
          last_bcd = ref_bcd(e.val);
        end
      end else begin
        check("bcd_hold", longint'(bcd), longint'(last_bcd));
      end
      done_prev = done;
    end else begin
      done_prev = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) check("idle_timeout", longint'(busy), 0);
  endtask

  // Issue one request; noise on start/bin during SHIFT must be ignored.
  task automatic issue(input int v, input bit hold);
    wait_idle();
    start = 1'b1;
    bin   = BIN_W'(v);
    step();
    exp_q.push_back('{v, cyc});
    check("busy_after_accept", longint'(busy), 1);
    for (int i = 0; i < BIN_W - 2; i++) begin
      start = 1'($urandom);
      bin   = BIN_W'($urandom);
      step();
    end
    start = hold;
    bin   = BIN_W'($urandom);
  endtask

  initial begin
    #2;
    rst_n = 1'b0;
    step();
    step();
    check("reset_busy", longint'(busy), 0);
    check("reset_done", longint'(done), 0);
    check("reset_bcd", longint'(bcd), 0);
`ifdef BCD_BLANK_EN
    check("reset_blank", longint'(blank), longint'(5'b11110));
`endif
    rst_n = 1'b1;
    step();

    issue(65535, 1'b0);
    issue(1000, 1'b0);
    issue(0, 1'b0);
    issue(42, 1'b0);
    issue(10000, 1'b0);
    issue(63, 1'b0);
    issue(10, 1'b1);
    issue(99, 1'b1);
    issue(100, 1'b1);
    issue(9999, 1'b0);

    // Asynchronous reset in the middle of a conversion.
    wait_idle();
    start = 1'b1;
    bin   = BIN_W'(12345);
    step();
    exp_q.push_back('{12345, cyc});
    start = 1'b0;
    repeat (7) step();
    rst_n = 1'b0;
    exp_q.delete();
    last_bcd = '0;
    #1;
    check("midrst_busy", longint'(busy), 0);
    check("midrst_done", longint'(done), 0);
    check("midrst_bcd", longint'(bcd), 0);
`ifdef BCD_BLANK_EN
    check("midrst_blank", longint'(blank), longint'(5'b11110));
`endif
    step();
    rst_n = 1'b1;
    step();
    issue(4321, 1'b0);

    for (int t = 0; t < 2000; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        wait_idle();
        start = 1'b0;
        repeat ($urandom_range(1, 3)) step();
      end
      issue(int'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
    end

    wait_idle();
    start = 1'b0;
    for (int n = 0; n < 50 && exp_q.size() != 0; n++) step();
    if (exp_q.size() != 0) check("drain", exp_q.size(), 0);
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
